// File: rtl/riscv_privileged_pkg.sv
// Privileged-architecture constants and shared types for the trap path.
// Holds trap cause codes, the trap record and the trap arbiter state encoding.
package riscv_privileged_pkg;

   localparam int unsigned XLEN      = 32;
   localparam int unsigned MXLEN     = 32;
   localparam int unsigned CodeWidth = MXLEN - 1;

   localparam int unsigned IrqMsi = 3;
   localparam int unsigned IrqMti = 7;
   localparam int unsigned IrqMei = 11;

   localparam int unsigned ExcInstrMisaligned  = 0;
   localparam int unsigned ExcInstrAccessFault = 1;
   localparam int unsigned ExcIllegalInstr     = 2;
   localparam int unsigned ExcBreakpoint       = 3;
   localparam int unsigned ExcLoadMisaligned   = 4;
   localparam int unsigned ExcLoadAccessFault  = 5;
   localparam int unsigned ExcStoreMisaligned  = 6;
   localparam int unsigned ExcStoreAccessFault = 7;
   localparam int unsigned ExcEcallM           = 11;

   typedef struct packed {
      logic                 interrupt;
      logic [CodeWidth-1:0] code;
      logic [XLEN-1:0]      epc;
      logic [MXLEN-1:0]     tval;
   } trap_record_t;

   typedef enum logic [1:0] {StIdle, StHold, StOffer, StDrain} state_t;

endpackage

// File: rtl/lagarto_trap_priority_select.sv
// Oldest-source picker: among asserted requests the highest index wins.
module lagarto_trap_priority_select
   import riscv_privileged_pkg::*;
#(
   parameter int unsigned NUM_SOURCES = 4,
   parameter int unsigned CAUSE_WIDTH = 5,
   parameter int unsigned IDX_WIDTH   = 2
) (
   input  logic [NUM_SOURCES-1:0]             valid,
   input  logic [NUM_SOURCES*CAUSE_WIDTH-1:0] cause,
   input  logic [NUM_SOURCES*XLEN-1:0]        pc,
   input  logic [NUM_SOURCES*MXLEN-1:0]       tval,
   output logic                               sel_valid,
   output logic [IDX_WIDTH-1:0]               sel_index,
   output logic [CAUSE_WIDTH-1:0]             sel_cause,
   output logic [XLEN-1:0]                    sel_pc,
   output logic [MXLEN-1:0]                   sel_tval
);

   always_comb begin
      sel_valid = 1'b0;
      sel_index = '0;
      sel_cause = '0;
      sel_pc    = '0;
      sel_tval  = '0;
      // Ascending scan so the last (oldest) asserted source overrides.
      for (int unsigned k = 0; k < NUM_SOURCES; k++) begin
         if (valid[k]) begin
            sel_valid = 1'b1;
            sel_index = IDX_WIDTH'(k);
            sel_cause = cause[k*CAUSE_WIDTH +: CAUSE_WIDTH];
            sel_pc    = pc[k*XLEN +: XLEN];
            sel_tval  = tval[k*MXLEN +: MXLEN];
         end
      end
   end

endmodule

// File: rtl/lagarto_trap_arbiter.sv
// Keeps the oldest pending trap, waits for it to reach the commit head and
// offers a single cause/epc/tval record to the exception handler.
module lagarto_trap_arbiter
   import riscv_privileged_pkg::*;
#(
   parameter int unsigned NUM_SOURCES = 4,
   parameter int unsigned CAUSE_WIDTH = 5
) (
   input  logic                             clock_i,
   input  logic                             reset_i,
   input  logic [NUM_SOURCES-1:0]           exception_valid_i,
   input  logic [NUM_SOURCES*CAUSE_WIDTH-1:0] exception_cause_i,
   input  logic [NUM_SOURCES*XLEN-1:0]      exception_pc_i,
   input  logic [NUM_SOURCES*MXLEN-1:0]     exception_tval_i,
   input  logic [MXLEN-1:0]                 interrupt_pending_i,
   input  logic                             global_interrupt_enable_i,
   input  logic                             head_valid_i,
   input  logic [XLEN-1:0]                  head_pc_i,
   input  logic                             instruction_retired_i,
   input  logic [XLEN-1:0]                  next_pc_i,
   input  logic                             squash_i,
   output logic                             trap_valid_o,
   input  logic                             trap_ready_i,
   output logic [MXLEN-1:0]                 trap_cause_o,
   output logic [XLEN-1:0]                  trap_epc_o,
   output logic [MXLEN-1:0]                 trap_tval_o,
   output logic                             trap_pending_o
);

   localparam int unsigned IdxWidth = (NUM_SOURCES > 1) ? $clog2(NUM_SOURCES) : 1;

   state_t               state_q;
   trap_record_t         rec_q;
   logic [IdxWidth-1:0]  src_q;
   logic                 trap_valid_q;
   logic                 trap_pending_q;

   logic                 sel_valid;
   logic [IdxWidth-1:0]  sel_index;
   logic [CAUSE_WIDTH-1:0] sel_cause;
   logic [XLEN-1:0]      sel_pc;
   logic [MXLEN-1:0]     sel_tval;

   trap_record_t         exc_rec;
   trap_record_t         irq_rec;
   logic                 irq_take;

   lagarto_trap_priority_select #(
      .NUM_SOURCES (NUM_SOURCES),
      .CAUSE_WIDTH (CAUSE_WIDTH),
      .IDX_WIDTH   (IdxWidth)
   ) u_select (
      .valid     (exception_valid_i),
      .cause     (exception_cause_i),
      .pc        (exception_pc_i),
      .tval      (exception_tval_i),
      .sel_valid (sel_valid),
      .sel_index (sel_index),
      .sel_cause (sel_cause),
      .sel_pc    (sel_pc),
      .sel_tval  (sel_tval)
   );

   always_comb begin
      exc_rec.interrupt = 1'b0;
      exc_rec.code      = CodeWidth'(sel_cause);
      exc_rec.epc       = sel_pc;
      exc_rec.tval      = sel_tval;

      irq_rec           = '0;
      irq_rec.interrupt = 1'b1;
      irq_rec.epc       = next_pc_i;
      irq_take          = global_interrupt_enable_i && instruction_retired_i;
      if (interrupt_pending_i[IrqMei]) begin
         irq_rec.code = CodeWidth'(IrqMei);
      end else if (interrupt_pending_i[IrqMsi]) begin
         irq_rec.code = CodeWidth'(IrqMsi);
      end else if (interrupt_pending_i[IrqMti]) begin
         irq_rec.code = CodeWidth'(IrqMti);
      end else begin
         irq_take = 1'b0;
      end
   end

   always_ff @(posedge clock_i or posedge reset_i) begin
      if (reset_i) begin
         state_q        <= StIdle;
         rec_q          <= '0;
         src_q          <= '0;
         trap_valid_q   <= 1'b0;
         trap_pending_q <= 1'b0;
      end else begin
         case (state_q)
            StIdle: begin
               if (sel_valid && !squash_i) begin
                  rec_q          <= exc_rec;
                  src_q          <= sel_index;
                  state_q        <= StHold;
                  trap_pending_q <= 1'b1;
               end else if (irq_take) begin
                  rec_q          <= irq_rec;
                  src_q          <= '0;
                  state_q        <= StOffer;
                  trap_valid_q   <= 1'b1;
                  trap_pending_q <= 1'b1;
               end
            end
            StHold: begin
               if (squash_i) begin
                  rec_q          <= '0;
                  src_q          <= '0;
                  state_q        <= StIdle;
                  trap_pending_q <= 1'b0;
               end else if (sel_valid && (sel_index > src_q)) begin
                  // Older replacement wins over a same-cycle head match.
                  rec_q <= exc_rec;
                  src_q <= sel_index;
               end else if (head_valid_i && (head_pc_i == rec_q.epc)) begin
                  state_q      <= StOffer;
                  trap_valid_q <= 1'b1;
               end
            end
            StOffer: begin
               if (trap_ready_i) begin
                  state_q        <= StDrain;
                  trap_valid_q   <= 1'b0;
                  trap_pending_q <= 1'b0;
               end
            end
            StDrain: begin
               state_q <= StIdle;
            end
            default: begin
               state_q        <= StIdle;
               trap_valid_q   <= 1'b0;
               trap_pending_q <= 1'b0;
            end
         endcase
      end
   end

   assign trap_valid_o   = trap_valid_q;
   assign trap_pending_o = trap_pending_q;
   assign trap_cause_o   = {rec_q.interrupt, rec_q.code};
   assign trap_epc_o     = rec_q.epc;
   assign trap_tval_o    = rec_q.tval;

endmodule

// File: tb/tb_lagarto_trap_arbiter.sv
// Bench for lagarto_trap_arbiter: directed scenarios followed by random traffic,
// all checked against a rule-level reference model.
module tb_lagarto_trap_arbiter;
   import riscv_privileged_pkg::*;

   localparam int unsigned NS = 4;
   localparam int unsigned CW = 5;

   logic                 clock = 1'b0;
   logic                 reset;
   logic [NS-1:0]        ev;
   logic [NS*CW-1:0]     ecause;
   logic [NS*XLEN-1:0]   epc_in;
   logic [NS*MXLEN-1:0]  etval;
   logic [MXLEN-1:0]     ip;
   logic                 mie;
   logic                 head_valid;
   logic [XLEN-1:0]      head_pc;
   logic                 retired;
   logic [XLEN-1:0]      next_pc;
   logic                 squash;
   logic                 ready;
   logic                 trap_valid;
   logic [MXLEN-1:0]     trap_cause;
   logic [XLEN-1:0]      trap_epc;
   logic [MXLEN-1:0]     trap_tval;
   logic                 trap_pending;

   int checks   = 0;
   int failures = 0;

   // Reference model: what trap is known, whether it is offered, drain pending.
   bit              m_held, m_offer, m_drain, m_int;
   int              m_src;
   logic [MXLEN-2:0] m_code;
   logic [XLEN-1:0]  m_epc;
   logic [MXLEN-1:0] m_tval;

   lagarto_trap_arbiter #(
      .NUM_SOURCES (NS),
      .CAUSE_WIDTH (CW)
   ) dut (
      .clock_i                   (clock),
      .reset_i                   (reset),
      .exception_valid_i         (ev),
      .exception_cause_i         (ecause),
      .exception_pc_i            (epc_in),
      .exception_tval_i          (etval),
      .interrupt_pending_i       (ip),
      .global_interrupt_enable_i (mie),
      .head_valid_i              (head_valid),
      .head_pc_i                 (head_pc),
      .instruction_retired_i     (retired),
      .next_pc_i                 (next_pc),
      .squash_i                  (squash),
      .trap_valid_o              (trap_valid),
      .trap_ready_i              (ready),
      .trap_cause_o              (trap_cause),
      .trap_epc_o                (trap_epc),
      .trap_tval_o               (trap_tval),
      .trap_pending_o            (trap_pending)
   );

   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_held = 0; m_offer = 0; m_drain = 0; m_int = 0; m_src = 0;
      m_code = '0; m_epc = '0; m_tval = '0;
   endtask

   task automatic model_load(input int k);
      m_int  = 0;
      m_src  = k;
      m_code = (MXLEN-1)'(ecause[k*CW +: CW]);
      m_epc  = epc_in[k*XLEN +: XLEN];
      m_tval = etval[k*MXLEN +: MXLEN];
   endtask

   task automatic model_step();
      int win = -1;
      for (int k = 0; k < NS; k++) if (ev[k]) win = k;
      if (m_offer) begin
         if (ready) begin m_offer = 0; m_drain = 1; end
      end else if (m_drain) begin
         m_drain = 0;
      end else if (m_held) begin
         if (squash) begin
            m_held = 0; m_int = 0; m_src = 0; m_code = '0; m_epc = '0; m_tval = '0;
         end else if (win > m_src) begin
            model_load(win);
         end else if (head_valid && head_pc == m_epc) begin
            m_held = 0; m_offer = 1;
         end
      end else if (win >= 0 && !squash) begin
         model_load(win);
         m_held = 1;
      end else if (mie && retired && (ip[11] || ip[3] || ip[7])) begin
         m_int  = 1; m_src = 0;
         m_code = ip[11] ? 31'd11 : (ip[3] ? 31'd3 : 31'd7);
         m_epc  = next_pc;
         m_tval = '0;
         m_offer = 1;
      end
   endtask

   task automatic check_model(input string tag);
      check({tag, ".valid"}, trap_valid, m_offer);
      check({tag, ".pending"}, trap_pending, m_held | m_offer);
      check({tag, ".cause"}, trap_cause, {m_int, m_code});
      check({tag, ".epc"}, trap_epc, m_epc);
      check({tag, ".tval"}, trap_tval, m_tval);
   endtask

   task automatic step(input string tag);
      model_step();
      @(posedge clock);
      #1;
      check_model(tag);
   endtask

   task automatic set_exc(input int k, input logic [CW-1:0] c, input logic [XLEN-1:0] pc,
                          input logic [MXLEN-1:0] tv);
      ev[k]                 = 1'b1;
      ecause[k*CW +: CW]    = c;
      epc_in[k*XLEN +: XLEN] = pc;
      etval[k*MXLEN +: MXLEN] = tv;
   endtask

   task automatic clear_exc();
      ev = '0; ecause = '0; epc_in = '0; etval = '0;
   endtask

   initial begin
      logic [XLEN-1:0] pcs [4];
      pcs = '{32'h100, 32'h104, 32'h108, 32'h10C};
      reset = 1'b1;
      clear_exc();
      ip = '0; mie = 0; head_valid = 0; head_pc = '0; retired = 0; next_pc = '0;
      squash = 0; ready = 0;
      model_reset();
      #12 reset = 1'b0;
      check_model("reset");

      // Illegal instruction at ID reaching OFFER two cycles after the request.
      ready = 1;
      set_exc(1, 5'd2, 32'h100, 32'hDEAD);
      step("ill.cap");
      check("ill.pending", trap_pending, 1);
      clear_exc();
      head_valid = 1; head_pc = 32'h100;
      step("ill.offer");
      check("ill.valid", trap_valid, 1);
      check("ill.cause", trap_cause, 32'h2);
      check("ill.epc", trap_epc, 32'h100);
      check("ill.tval", trap_tval, 32'hDEAD);
      head_valid = 0;
      step("ill.drain");
      set_exc(3, 5'd5, 32'h300, 32'h1);
      step("drain.ignore");
      check("drain.ignored", trap_pending, 0);
      step("drain.over");
      check("drain.one_cycle", trap_pending, 1);
      clear_exc();
      squash = 1;
      step("squash.hold");
      check("squash.pending", trap_pending, 0);
      squash = 0; ready = 0;

      // Older replacement; the younger record's PC at the head is ignored.
      set_exc(0, 5'd1, 32'h200, 32'h200);
      step("repl.first");
      clear_exc();
      set_exc(3, 5'd4, 32'h1F0, 32'h1F3);
      step("repl.older");
      clear_exc();
      set_exc(2, 5'd6, 32'h1E0, 32'h0);
      head_valid = 1; head_pc = 32'h200;
      step("repl.younger");
      clear_exc();
      step("repl.nomatch");
      check("repl.cause", trap_cause, 32'h4);
      check("repl.epc", trap_epc, 32'h1F0);
      check("repl.not_offered", trap_valid, 0);
      head_pc = 32'h1F0;
      step("repl.offer");
      head_valid = 0; ready = 1;
      step("repl.drain");
      ready = 0;
      step("repl.idle");

      // MTI + MEI pending on a retiring cycle, with and without MIE.
      ip = (32'd1 << 7) | (32'd1 << 11); mie = 1; retired = 1; next_pc = 32'h400;
      step("irq.take");
      check("irq.cause", trap_cause, 32'h8000000B);
      check("irq.epc", trap_epc, 32'h400);
      check("irq.tval", trap_tval, 32'h0);
      check("irq.valid", trap_valid, 1);
      retired = 0; ready = 1;
      step("irq.drain");
      ready = 0;
      step("irq.idle");
      mie = 0; retired = 1;
      step("irq.masked");
      check("irq.masked_valid", trap_valid, 0);

      // Exception beats a same-cycle interrupt.
      mie = 1; ip = 32'd1 << 3;
      set_exc(2, 5'd5, 32'h300, 32'h55);
      step("race.cap");
      check("race.exc_cause", trap_cause, 32'h5);
      check("race.not_offered", trap_valid, 0);
      clear_exc(); retired = 0; ip = '0;
      head_valid = 1; head_pc = 32'h300;
      step("race.offer");
      head_valid = 0; ready = 1;
      step("race.drain");
      ready = 0;
      step("race.idle");

      // OFFER held five cycles with distractions, then async reset mid-OFFER.
      ip = 32'd1 << 7; retired = 1; next_pc = 32'h500;
      step("stall.take");
      retired = 0;
      for (int i = 0; i < 5; i++) begin
         set_exc(i % NS, 5'd3, 32'h600, 32'h7);
         squash = (i == 2);
         step("stall.hold");
         check("stall.cause", trap_cause, 32'h80000007);
         check("stall.epc", trap_epc, 32'h500);
      end
      clear_exc(); squash = 0; ip = '0;
      #2 reset = 1'b1;
      #1;
      check("areset.valid", trap_valid, 0);
      check("areset.pending", trap_pending, 0);
      check("areset.cause", trap_cause, 0);
      model_reset();
      #1 reset = 1'b0;
      step("areset.idle");

      // Random traffic.
      for (int n = 0; n < 500; n++) begin
         for (int k = 0; k < NS; k++) begin
            ev[k] = ($urandom_range(7) == 0);
            ecause[k*CW +: CW] = CW'($urandom);
            epc_in[k*XLEN +: XLEN] = pcs[$urandom_range(3)];
            etval[k*MXLEN +: MXLEN] = $urandom;
         end
         ip         = $urandom;
         if ($urandom_range(1) == 0) ip = ip & ~32'h888;
         mie        = $urandom_range(1) == 1;
         retired    = $urandom_range(1) == 1;
         next_pc    = $urandom;
         squash     = ($urandom_range(15) == 0);
         ready      = $urandom_range(1) == 1;
         head_valid = $urandom_range(3) != 0;
         head_pc    = ($urandom_range(1) == 1) ? m_epc : pcs[$urandom_range(3)];
         step("rand");
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
